// File: rtl/inst_loader.sv
// Program loader: assembles big-endian bytes from a serial stream into 32-bit
// instruction words, writes them to instruction memory, and releases the PC on HALT.
module inst_loader #(
    parameter int ADDR_BITS  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  wr_en,
    output logic [ADDR_BITS-1:0]  wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  pc_reset,
    output logic                  pc_enable,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        ERROR = 2'd3
    } state_t;

    localparam logic [ADDR_BITS-1:0]  LAST_IDX = ADDR_BITS'(MEM_WORDS - 1);
    localparam logic [ADDR_BITS-1:0]  IDX_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] HALT     = {DATA_WIDTH{1'b1}};

    state_t                  state_reg, state_next;
    logic [DATA_WIDTH-1:0]   asm_reg, asm_next;
    logic [1:0]              cnt_reg, cnt_next;
    logic [ADDR_BITS-1:0]    idx_reg, idx_next;
    logic                    wr_en_reg, wr_en_next;
    logic [DATA_WIDTH-1:0]   wr_data_reg, wr_data_next;
    logic                    pc_reset_reg, pc_reset_next;
    logic                    pc_enable_reg, pc_enable_next;
    logic                    done_reg, done_next;
    logic                    error_reg, error_next;
    logic [DATA_WIDTH-1:0]   shifted;

    assign shifted = {asm_reg[DATA_WIDTH-9:0], rx_data};

    always_comb begin
        state_next   = state_reg;
        asm_next     = asm_reg;
        cnt_next     = cnt_reg;
        idx_next     = idx_reg;
        wr_en_next   = 1'b0;
        wr_data_next = wr_data_reg;

        case (state_reg)
            IDLE, RUN, ERROR: begin
                if (start) begin
                    state_next = LOAD;
                    asm_next   = '0;
                    cnt_next   = 2'd0;
                    idx_next   = '0;
                end
            end
            LOAD: begin
                // A byte arriving during the write cycle starts the next word.
                if (rx_valid) begin
                    asm_next = shifted;
                    cnt_next = cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3) begin
                        wr_en_next   = 1'b1;
                        wr_data_next = shifted;
                    end
                end
                if (wr_en_reg) begin
                    idx_next = idx_reg + IDX_ONE;
                    if (wr_data_reg == HALT) begin
                        state_next = RUN;
                    end else if (idx_reg == LAST_IDX) begin
                        state_next = ERROR;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        pc_reset_next  = (state_next != RUN);
        pc_enable_next = (state_next == RUN);
        done_next      = (state_next == RUN);
        error_next     = (state_next == ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            asm_reg       <= '0;
            cnt_reg       <= 2'd0;
            idx_reg       <= '0;
            wr_en_reg     <= 1'b0;
            wr_data_reg   <= '0;
            pc_reset_reg  <= 1'b1;
            pc_enable_reg <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            asm_reg       <= asm_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            wr_en_reg     <= wr_en_next;
            wr_data_reg   <= wr_data_next;
            pc_reset_reg  <= pc_reset_next;
            pc_enable_reg <= pc_enable_next;
            done_reg      <= done_next;
            error_reg     <= error_next;
        end
    end

    assign wr_en     = wr_en_reg;
    assign wr_addr   = idx_reg;
    assign wr_data   = wr_data_reg;
    assign pc_reset  = pc_reset_reg;
    assign pc_enable = pc_enable_reg;
    assign done      = done_reg;
    assign error     = error_reg;

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
Parameters:
REQ-001 SHALL have parameter ADDR_BITS, default 32: width of instruction-memory word address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: instruction width; fixed at 4 bytes.
REQ-003 SHALL have parameter MEM_WORDS, default 256: instruction-memory capacity in words.
Ports:
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a program load.
REQ-007 SHALL have port rx_data  input  8  incoming program byte.
REQ-008 SHALL have port rx_valid  input  1  one-cycle strobe marking rx_data valid.
REQ-009 SHALL have port wr_en  output  1  instruction-memory write strobe.
REQ-010 SHALL have port wr_addr  output  ADDR_BITS  instruction-memory word address.
REQ-011 SHALL have port wr_data  output  DATA_WIDTH  instruction word to write.
REQ-012 SHALL have port pc_reset  output  1  holds the fetch-stage PC at 0.
REQ-013 SHALL have port pc_enable  output  1  allows the fetch-stage PC to advance.
REQ-014 SHALL have port done  output  1  level; program loaded and running.
REQ-015 SHALL have port error  output  1  level; memory overflowed before HALT.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, RUN, ERROR; all outputs registered.
REQ-017 IDLE: start=1 -> LOAD; rx_valid ignored.
REQ-018 LOAD: each rx_valid=1 byte shifts into a 32-bit assembly register, first byte = bits 31:24 (big-endian); 2-bit byte counter increments.
REQ-019 On the edge accepting the 4th byte, the next cycle SHALL show wr_en=1 for exactly one cycle, with wr_data = assembled word and wr_addr = current word index.
REQ-020 wr_addr SHALL increment by 1 on the edge after each write; word index starts at 0 on entry to LOAD.
REQ-021 Written word 0xFFFFFFFF (HALT) SHALL still be written; the edge ending that wr_en cycle -> RUN.
REQ-022 Non-HALT write at word index MEM_WORDS-1 -> ERROR on the edge ending that wr_en cycle.
REQ-023 rx_valid during the wr_en cycle SHALL be accepted as byte 0 of the next word, with no loss.
REQ-024 start in LOAD SHALL be ignored.
REQ-025 RUN: pc_reset=0, pc_enable=1, done=1; rx_valid ignored; start=1 -> LOAD with byte counter and word index cleared and done cleared.
REQ-026 ERROR: error=1, pc_reset=1, pc_enable=0; rx_valid ignored; start=1 -> LOAD with error cleared and counters cleared.
REQ-027 In IDLE, LOAD and ERROR: pc_reset=1, pc_enable=0, so the PC leaves reset at 0 on the first RUN cycle.
REQ-028 A partial word (fewer than 4 bytes) SHALL never be written.
REQ-029 wr_en SHALL be 0 in every state except the write cycle in LOAD.

Reset
REQ-030 reset=1 at a clock edge SHALL force IDLE, wr_en=0, wr_addr=0, wr_data=0, pc_reset=1, pc_enable=0, done=0, error=0, byte counter=0, word index=0.
REQ-031 reset SHALL take priority over start and rx_valid; reset in mid-LOAD SHALL discard the partial word with no write.

Verification
REQ-032 Load bytes 20 01 00 05, FF FF FF FF -> writes (0, 0x20010005), then (1, 0xFFFFFFFF); next cycle done=1, pc_reset=0, pc_enable=1.
REQ-033 Bytes 12 34 on back-to-back cycles, then 56 78 with 3-cycle gaps -> a single write of 0x12345678 at addr 0, one cycle after byte 78.
REQ-034 MEM_WORDS=4, four non-HALT words -> 4 writes at addrs 0..3, then error=1, pc_enable=0; further bytes produce no wr_en.
REQ-035 Byte 0 of the next word on the wr_en cycle -> that byte lands in bits 31:24 of the next word.
REQ-036 reset after 2 bytes of word 1, then start and reload -> no write of the partial word; the reload starts at addr 0.
REQ-037 start in RUN, then bytes AA BB CC DD FF FF FF FF -> done drops, pc_reset=1, writes start again at addr 0, RUN is re-entered.
